// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sample front end: default sizing, the sample word type
// and the index-width helper used by the deserializer and its frame banks.
package fft_pkg;
   localparam int DEF_BIT_WIDTH = 32;
   localparam int DEF_N_SAMPLES = 8;
   localparam int IDX_W         = $clog2(DEF_N_SAMPLES);

   typedef logic [DEF_BIT_WIDTH-1:0] sample_t;

   // Width of a sample index within a frame; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer of N_SAMPLES words with an indexed write port, a full flag
// (set/clear) and the whole frame visible in parallel on rd_data.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int N_SAMPLES = DEF_N_SAMPLES,
   localparam int AW       = idx_width(N_SAMPLES)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                wr_en,
   input  logic [AW-1:0]                       wr_idx,
   input  logic [BIT_WIDTH-1:0]                wr_data,
   input  logic                                set_full,
   input  logic                                clr_full,
   output logic                                full,
   output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] rd_data
);

   logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] mem;

   // Words are cleared on reset so no stale frame can ever reach the FFT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem  <= '0;
         full <= 1'b0;
      end else begin
         if (wr_en)
            mem[wr_idx] <= wr_data;
         if (set_full)
            full <= 1'b1;
         else if (clr_full)
            full <= 1'b0;
      end
   end

   assign rd_data = mem;

endmodule

// File: rtl/fft_sample_deserializer.sv
// Serial-to-parallel front end for the FFT: samples stream into one of two frame banks
// while the other bank is offered to the FFT as a complete frame.
module fft_sample_deserializer
   import fft_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int N_SAMPLES = DEF_N_SAMPLES,
   localparam int AW       = idx_width(N_SAMPLES)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [BIT_WIDTH-1:0]                recv_msg,
   input  logic                                recv_val,
   output logic                                recv_rdy,
   output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg,
   output logic                                send_val,
   input  logic                                send_rdy
);

   logic                                     wr_bank;
   logic                                     rd_bank;
   logic [AW-1:0]                            wr_idx;
   logic [1:0]                               full;
   logic [1:0][N_SAMPLES-1:0][BIT_WIDTH-1:0] bank_data;
   logic                                     recv_fire;
   logic                                     send_fire;
   logic                                     last_word;

   assign recv_fire = recv_val && recv_rdy;
   assign send_fire = send_val && send_rdy;
   assign last_word = (wr_idx == AW'(N_SAMPLES - 1));

   for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic BSEL = 1'(b);

      fft_frame_bank #(
         .BIT_WIDTH (BIT_WIDTH),
         .N_SAMPLES (N_SAMPLES)
      ) u_bank (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (recv_fire && (wr_bank == BSEL)),
         .wr_idx   (wr_idx),
         .wr_data  (recv_msg),
         .set_full (recv_fire && last_word && (wr_bank == BSEL)),
         .clr_full (send_fire && (rd_bank == BSEL)),
         .full     (full[b]),
         .rd_data  (bank_data[b])
      );
   end

   // Both handshake outputs come straight from bank flags and pointers (registers only).
   assign recv_rdy = !full[wr_bank];
   assign send_val = full[rd_bank];
   assign send_msg = bank_data[rd_bank];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
      end else begin
         if (recv_fire) begin
            if (last_word) begin
               wr_idx  <= '0;
               wr_bank <= !wr_bank;
            end else begin
               wr_idx  <= wr_idx + 1'b1;
            end
         end
         if (send_fire)
            rd_bank <= !rd_bank;
      end
   end

endmodule

// File: tb/tb_fft_sample_deserializer.sv
// Directed bench for fft_sample_deserializer: vector table for fill/drain, hand sequences for
// the overlap and reset corners, a frame-queue model for random traffic, and an N_SAMPLES=2 build.
module tb_fft_sample_deserializer;

   typedef logic [7:0][31:0] frame_t;

   typedef struct {
      logic        rv;
      logic [31:0] msg;
      logic        sr;
      logic        exp_rdy;
      logic        exp_val;
      frame_t      exp_msg;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] recv_msg;
   logic        recv_val;
   logic        recv_rdy;
   frame_t      send_msg;
   logic        send_val;
   logic        send_rdy;

   logic [31:0]      recv_msg2;
   logic             recv_val2;
   logic             recv_rdy2;
   logic [1:0][31:0] send_msg2;
   logic             send_val2;
   logic             send_rdy2;

   int checks = 0;
   int errors = 0;

   vec_t tbl[30];

   fft_sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .recv_msg (recv_msg),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .send_msg (send_msg),
      .send_val (send_val),
      .send_rdy (send_rdy)
   );

   fft_sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(2)) dut2 (
      .clk      (clk),
      .reset    (rst_n),
      .recv_msg (recv_msg2),
      .recv_val (recv_val2),
      .recv_rdy (recv_rdy2),
      .send_msg (send_msg2),
      .send_val (send_val2),
      .send_rdy (send_rdy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic frame_t ramp(input int start);
      frame_t f;
      for (int k = 0; k < 8; k++) f[k] = 32'(start + k);
      return f;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [31:0] msg, input logic sr);
      @(negedge clk);
      recv_val = rv;
      recv_msg = msg;
      send_rdy = sr;
   endtask

   task automatic run_vec(input int i);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), recv_rdy, tbl[i].exp_rdy);
      chk($sformatf("vec%0d_val", i), send_val, tbl[i].exp_val);
      if (tbl[i].exp_val)
         chk($sformatf("vec%0d_msg", i), send_msg, tbl[i].exp_msg);
      recv_val = tbl[i].rv;
      recv_msg = tbl[i].msg;
      send_rdy = tbl[i].sr;
   endtask

   initial begin
      frame_t q[$];
      frame_t cur;
      int     cur_n, pushed, sent, cycles;
      logic   rf, sf;

      // Test 1: back-to-back 1..8, FFT always ready.
      for (int i = 0; i < 8; i++)
         tbl[i] = '{rv: 1'b1, msg: 32'(i + 1), sr: 1'b1, exp_rdy: 1'b1, exp_val: 1'b0, exp_msg: '0};
      tbl[8] = '{rv: 1'b0, msg: '0, sr: 1'b1, exp_rdy: 1'b1, exp_val: 1'b1, exp_msg: ramp(1)};
      tbl[9] = '{rv: 1'b0, msg: '0, sr: 1'b0, exp_rdy: 1'b1, exp_val: 1'b0, exp_msg: '0};
      // Test 2: 10..25 with FFT stalled, then drain both frames.
      for (int i = 0; i < 16; i++)
         tbl[10 + i] = '{rv: 1'b1, msg: 32'(10 + i), sr: 1'b0, exp_rdy: 1'b1,
                         exp_val: (i >= 8), exp_msg: ramp(10)};
      tbl[26] = '{rv: 1'b0, msg: '0, sr: 1'b0, exp_rdy: 1'b0, exp_val: 1'b1, exp_msg: ramp(10)};
      tbl[27] = '{rv: 1'b0, msg: '0, sr: 1'b1, exp_rdy: 1'b0, exp_val: 1'b1, exp_msg: ramp(10)};
      tbl[28] = '{rv: 1'b0, msg: '0, sr: 1'b1, exp_rdy: 1'b1, exp_val: 1'b1, exp_msg: ramp(18)};
      tbl[29] = '{rv: 1'b0, msg: '0, sr: 1'b0, exp_rdy: 1'b1, exp_val: 1'b0, exp_msg: '0};

      rst_n     = 1'b0;
      recv_val  = 1'b0;
      recv_msg  = '0;
      send_rdy  = 1'b0;
      recv_val2 = 1'b0;
      recv_msg2 = '0;
      send_rdy2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_rdy", recv_rdy, 1'b1);
      chk("reset_val", send_val, 1'b0);
      chk("reset_msg", send_msg, '0);
      chk("reset_rdy2", recv_rdy2, 1'b1);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) run_vec(i);

      // Test 5: bank1 completes in the same cycle bank0 is taken by the FFT.
      for (int i = 0; i < 8; i++) drive(1'b1, 32'h200 + 32'(i), 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0);
      @(negedge clk);
      chk("ovl_pre_val", send_val, 1'b1);
      chk("ovl_pre_msg", send_msg, ramp('h200));
      chk("ovl_pre_rdy", recv_rdy, 1'b1);
      recv_val = 1'b1; recv_msg = 32'h307; send_rdy = 1'b1;
      @(negedge clk);
      chk("ovl_val", send_val, 1'b1);
      chk("ovl_msg", send_msg, ramp('h300));
      chk("ovl_rdy", recv_rdy, 1'b1);
      recv_val = 1'b0; send_rdy = 1'b1;
      @(negedge clk);
      chk("ovl_drain_val", send_val, 1'b0);
      send_rdy = 1'b0;

      // Test 3: random gaps and backpressure against a frame-queue model.
      cur = '0; cur_n = 0; pushed = 0; sent = 0; cycles = 0;
      while (sent < 100 && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         chk("rnd_rdy", recv_rdy, q.size() < 2);
         chk("rnd_val", send_val, q.size() > 0);
         if (q.size() > 0) chk("rnd_msg", send_msg, q[0]);
         recv_val = (pushed < 800) && ($urandom_range(0, 99) < 70);
         recv_msg = $urandom;
         send_rdy = ($urandom_range(0, 99) < 60);
         rf = recv_val && (q.size() < 2);
         sf = send_rdy && (q.size() > 0);
         if (sf) begin
            void'(q.pop_front());
            sent++;
         end
         if (rf) begin
            cur[cur_n] = recv_msg;
            cur_n++;
            pushed++;
            if (cur_n == 8) begin
               q.push_back(cur);
               cur_n = 0;
            end
         end
      end
      chk("rnd_frames_sent", 32'(sent), 32'd100);
      recv_val = 1'b0;
      send_rdy = 1'b0;

      // Test 4: reset partway through a frame discards it.
      for (int i = 0; i < 5; i++) drive(1'b1, 32'h400 + 32'(i), 1'b0);
      @(negedge clk);
      recv_val = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_val", send_val, 1'b0);
      chk("rst_mid_rdy", recv_rdy, 1'b1);
      chk("rst_mid_msg", send_msg, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0);
      @(negedge clk);
      recv_val = 1'b0;
      chk("rst_new_val", send_val, 1'b1);
      chk("rst_new_msg", send_msg, ramp('h100));
      send_rdy = 1'b1;
      @(negedge clk);
      chk("rst_after_val", send_val, 1'b0);
      chk("rst_after_rdy", recv_rdy, 1'b1);
      send_rdy = 1'b0;

      // Test 6: two-sample build passes words through bit-exact.
      @(negedge clk);
      recv_val2 = 1'b1; recv_msg2 = 32'h0001_0000;
      @(negedge clk);
      recv_msg2 = 32'hFFFF_0000;
      @(negedge clk);
      recv_val2 = 1'b0;
      chk("n2_val", send_val2, 1'b1);
      chk("n2_msg", send_msg2, {32'hFFFF_0000, 32'h0001_0000});
      send_rdy2 = 1'b1;
      @(negedge clk);
      chk("n2_after_val", send_val2, 1'b0);
      send_rdy2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
